// File: rtl/lkmem_arbiter_pkg.sv
// Shared identifiers for the item/link memory arbiter: requester IDs,
// FSM encodings and small helpers for 2-bit requester indices.
package lkmem_arbiter_pkg;

  localparam int NREQ = 3;

  // Requester IDs
  localparam logic [1:0] RQ_WALK = 2'd0;  // list-sum walker (reads)
  localparam logic [1:0] RQ_VEND = 2'd1;  // vend unit (read-modify-write)
  localparam logic [1:0] RQ_RSTK = 2'd2;  // restock loader (writes)

  // Arbiter FSM encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  // Index value 3 does not name a requester; treat it as requester 0.
  function automatic logic [1:0] legal_id(input logic [1:0] id);
    return (id == 2'd3) ? RQ_WALK : id;
  endfunction

  // Cyclic successor 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_id(input logic [1:0] id);
    logic [1:0] l;
    l = legal_id(id);
    return (l == RQ_RSTK) ? RQ_WALK : (l + 2'd1);
  endfunction

  // One-hot vector for a requester index.
  function automatic logic [NREQ-1:0] id_onehot(input logic [1:0] id);
    logic [NREQ-1:0] v;
    v = '0;
    v[legal_id(id)] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/lkmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester set in (req & ~excl),
// searching cyclically from ptr.
module rr_pick
  import lkmem_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic [2:0] excl,
  output logic [2:0] onehot,
  output logic       any,
  output logic [1:0] idx
);

  logic [2:0] cand;

  assign cand = req & ~excl;
  assign any  = |cand;

  // Priority search starting at the pointer position.
  always_comb begin
    idx = RQ_WALK;
    case (legal_id(ptr))
      RQ_VEND: begin
        if (cand[1])      idx = RQ_VEND;
        else if (cand[2]) idx = RQ_RSTK;
        else if (cand[0]) idx = RQ_WALK;
      end
      RQ_RSTK: begin
        if (cand[2])      idx = RQ_RSTK;
        else if (cand[0]) idx = RQ_WALK;
        else if (cand[1]) idx = RQ_VEND;
      end
      default: begin
        if (cand[0])      idx = RQ_WALK;
        else if (cand[1]) idx = RQ_VEND;
        else if (cand[2]) idx = RQ_RSTK;
      end
    endcase
  end

  assign onehot = any ? id_onehot(idx) : 3'b000;

endmodule

// File: rtl/lkmem_arbiter.sv
// Item/link memory port arbiter for walker, vend unit and restock loader.
// Handshake: a cycle with gnt[i]=1 and req[i]=1 is exactly one completed
// access; the requester moves on (new addr or req low) at the next edge.
// Reads return rdata with rvalid[i] one cycle after the access. A granted
// owner holding req & lock keeps the grant for up to MAX_LOCK cycles, which
// makes a read followed by a write at the same address atomic.
module lkmem_arbiter
  import lkmem_arbiter_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        lock,
  input  logic [2:0]        we,
  input  logic [3*AW-1:0]   addr,
  input  logic [3*DW-1:0]   wdata,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [DW-1:0]     rdata,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [0:0]    state;
  logic [1:0]    owner;
  logic [1:0]    ptr;
  logic [CW-1:0] lcnt;

  logic [1:0] own;
  logic       owning;
  logic       access;
  logic       hold;
  logic       capped;
  logic [1:0] pick_ptr;
  logic [2:0] pick_excl;
  logic [2:0] pick_onehot;
  logic       pick_any;
  logic [1:0] pick_idx;

  assign own    = legal_id(owner);
  assign owning = (state == ST_OWN);
  assign access = gnt[own] & req[own];
  assign capped = (lcnt >= CNT_MAX);
  assign hold   = owning & req[own] & lock[own] & ~capped;

  // On a release the search restarts after the old owner; an owner that hit
  // the lock limit sits out this one pick so others cannot be starved.
  assign pick_ptr  = owning ? next_id(own) : ptr;
  assign pick_excl = (owning && capped) ? id_onehot(own) : 3'b000;

  rr_pick u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .excl   (pick_excl),
    .onehot (pick_onehot),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  // Memory port follows the current owner; quiet when nothing is granted.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (|gnt) begin
      mem_addr  = addr[int'(own)*AW +: AW];
      mem_wdata = wdata[int'(own)*DW +: DW];
    end
  end

  assign mem_we = access & we[own];
  assign rdata  = mem_rdata;

  // Grant FSM, round-robin pointer, lock counter and read-valid pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      owner  <= RQ_WALK;
      ptr    <= 2'd0;
      lcnt   <= '0;
      gnt    <= 3'b000;
      rvalid <= 3'b000;
    end else begin
      rvalid <= (access && !we[own]) ? id_onehot(own) : 3'b000;
      if (hold) begin
        lcnt <= lcnt + CNT_ONE;
      end else begin
        if (owning) ptr <= next_id(own);
        if (pick_any) begin
          state <= ST_OWN;
          owner <= pick_idx;
          gnt   <= pick_onehot;
          lcnt  <= CNT_ONE;
        end else begin
          state <= ST_IDLE;
          gnt   <= 3'b000;
          lcnt  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lkmem_arbiter.sv
// Bench for lkmem_arbiter: behavioural arbitration/RAM model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_lkmem_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 16;
  localparam int MAX_LOCK = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [2:0]      req, lock, we;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  lkmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // ---------------- synchronous-read RAM ----------------
  logic [DW-1:0] ram [256];
  logic          ram_load = 1'b1;

  always @(posedge clock) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'hA000 | 16'(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int i);
    return wdata[i*DW +: DW];
  endfunction

  // First pending requester from start, cyclically, skipping excl (-1 = none).
  function automatic int pick(input logic [2:0] r, input int start, input int excl);
    for (int k = 0; k < 3; k++) begin
      int c = (start + k) % 3;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  // ---------------- model + per-cycle compare ----------------
  logic [DW-1:0] ref_mem [256];
  int            m_owner = -1;
  int            m_ptr   = 0;
  int            m_cnt   = 0;
  int            m_rv    = -1;
  logic [DW-1:0] m_rdata = '0;
  bit            m_valid = 1'b0;
  logic [2:0]    e_gnt, e_rv;
  int            nrv, excl;
  bit            acc;

  always @(negedge clock) begin
    if (!m_valid) for (int i = 0; i < 256; i++) ref_mem[i] = 16'hA000 | 16'(i);
    if (m_valid) begin
      e_gnt = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
      e_rv  = (m_rv >= 0) ? (3'b001 << m_rv) : 3'b000;
      chk("gnt", gnt, e_gnt);
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      assert ($onehot0(gnt)) else $error("FAIL gnt not one-hot: %b", gnt);
      chk("rvalid", rvalid, e_rv);
      if (m_rv >= 0) chk("rdata", rdata, m_rdata);
      chk("mem_addr", mem_addr, (m_owner >= 0) ? addr_of(m_owner) : '0);
      chk("mem_we", mem_we, (m_owner >= 0) ? (req[m_owner] & we[m_owner]) : 1'b0);
      if (m_owner >= 0) chk("mem_wdata", mem_wdata, wdata_of(m_owner));
    end
    // Advance the model by one edge using this cycle's inputs.
    acc = (m_owner >= 0) && req[m_owner];
    nrv = -1;
    if (acc) begin
      if (we[m_owner]) ref_mem[addr_of(m_owner)] = wdata_of(m_owner);
      else begin
        nrv     = m_owner;
        m_rdata = ref_mem[addr_of(m_owner)];
      end
    end
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_rv = -1; m_valid = 1'b1;
    end else begin
      m_rv = nrv;
      if (m_owner < 0) begin
        m_owner = pick(req, m_ptr, -1);
        m_cnt   = (m_owner >= 0) ? 1 : 0;
      end else if (req[m_owner] && lock[m_owner] && m_cnt < MAX_LOCK) begin
        m_cnt++;
      end else begin
        excl    = (m_cnt >= MAX_LOCK) ? m_owner : -1;
        m_ptr   = (m_owner + 1) % 3;
        m_owner = pick(req, m_ptr, excl);
        m_cnt   = (m_owner >= 0) ? 1 : 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic at_mid();
    @(negedge clock);
  endtask

  task automatic clear_all();
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
  endtask

  task automatic set_rq(input int i, input bit r, input bit l, input bit w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]            = r;
    lock[i]           = l;
    we[i]             = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    clear_all();
    repeat (n) next_cycle();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_all();
    repeat (n) next_cycle();
  endtask

  // ---------------- directed scenarios ----------------
  logic [2:0] rr_seq [4];

  initial begin
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;
    reset = 1'b1;
    clear_all();
    next_cycle();
    ram_load = 1'b0;
    next_cycle();
    at_mid();
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_rvalid", rvalid, 3'b000);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_we", mem_we, 1'b0);

    // Single read by the walker.
    next_cycle();
    reset = 1'b0;
    set_rq(0, 1, 0, 0, 8'h10, 16'h0);
    next_cycle();
    at_mid();
    chk("t1_gnt", gnt, 3'b001);
    chk("t1_mem_addr", mem_addr, 8'h10);
    next_cycle();
    clear_all();
    at_mid();
    chk("t1_rvalid", rvalid, 3'b001);
    chk("t1_rdata", rdata, 16'hA010);
    idle(2);

    // Round-robin over three constant requesters.
    do_reset(1);
    set_rq(0, 1, 0, 0, 8'h01, 16'h0);
    set_rq(1, 1, 0, 0, 8'h02, 16'h0);
    set_rq(2, 1, 0, 0, 8'h03, 16'h0);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      at_mid();
      chk("t2_rr_gnt", gnt, rr_seq[c]);
    end
    // lock asserted on a non-requesting, non-owning requester is ignored.
    next_cycle();
    set_rq(2, 0, 1, 0, 8'h03, 16'h0);
    repeat (4) next_cycle();
    idle(2);

    // Atomic RMW by the vend unit under lock, others pending.
    do_reset(1);
    set_rq(1, 1, 1, 0, 8'h20, 16'h0);
    next_cycle();
    set_rq(0, 1, 0, 0, 8'h40, 16'h0);
    set_rq(2, 1, 0, 0, 8'h41, 16'h0);
    at_mid();
    chk("t3_gnt_c1", gnt, 3'b010);
    next_cycle();
    at_mid();
    chk("t3_gnt_c2", gnt, 3'b010);
    chk("t3_rvalid_c2", rvalid, 3'b010);
    chk("t3_rdata_c2", rdata, 16'hA020);
    next_cycle();
    set_rq(1, 1, 1, 1, 8'h20, 16'hA021);
    at_mid();
    chk("t3_gnt_c3", gnt, 3'b010);
    chk("t3_mem_we_c3", mem_we, 1'b1);
    chk("t3_mem_addr_c3", mem_addr, 8'h20);
    chk("t3_mem_wdata_c3", mem_wdata, 16'hA021);
    next_cycle();
    set_rq(1, 1, 1, 0, 8'h20, 16'h0);
    at_mid();
    chk("t3_gnt_c4", gnt, 3'b010);
    next_cycle();
    set_rq(1, 0, 0, 0, 8'h00, 16'h0);
    at_mid();
    chk("t3_gnt_c5", gnt, 3'b100);
    chk("t3_rvalid_c5", rvalid, 3'b010);
    chk("t3_rdata_c5", rdata, 16'hA021);
    next_cycle();
    at_mid();
    chk("t3_gnt_c6", gnt, 3'b001);
    idle(3);

    // Lone locked requester: forced release leaves one idle cycle.
    do_reset(1);
    set_rq(1, 1, 1, 0, 8'h21, 16'h0);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      at_mid();
      chk("t4_gnt_locked", gnt, 3'b010);
    end
    next_cycle();
    at_mid();
    chk("t4_gnt_gap", gnt, 3'b000);
    next_cycle();
    at_mid();
    chk("t4_gnt_again", gnt, 3'b010);
    idle(3);

    // Restock write then walker read of the same word.
    set_rq(2, 1, 0, 1, 8'h05, 16'hBEEF);
    next_cycle();
    at_mid();
    chk("t5_gnt_w", gnt, 3'b100);
    chk("t5_mem_we_w", mem_we, 1'b1);
    chk("t5_mem_addr_w", mem_addr, 8'h05);
    chk("t5_mem_wdata_w", mem_wdata, 16'hBEEF);
    next_cycle();
    set_rq(2, 0, 0, 0, 8'h00, 16'h0);
    set_rq(0, 1, 0, 0, 8'h05, 16'h0);
    at_mid();
    chk("t5_mem_we_after", mem_we, 1'b0);
    chk("t5_rvalid_after_w", rvalid, 3'b000);
    next_cycle();
    at_mid();
    chk("t5_gnt_r", gnt, 3'b001);
    chk("t5_mem_addr_r", mem_addr, 8'h05);
    next_cycle();
    clear_all();
    at_mid();
    chk("t5_rvalid_r", rvalid, 3'b001);
    chk("t5_rdata_r", rdata, 16'hBEEF);
    idle(3);

    // Reset in the cycle of a read grant drops the pending rvalid.
    set_rq(0, 1, 0, 0, 8'h30, 16'h0);
    next_cycle();
    reset = 1'b1;
    at_mid();
    chk("t6_gnt_pre", gnt, 3'b001);
    next_cycle();
    reset = 1'b0;
    clear_all();
    set_rq(1, 1, 0, 0, 8'h31, 16'h0);
    set_rq(2, 1, 0, 0, 8'h32, 16'h0);
    at_mid();
    chk("t6_gnt_rst", gnt, 3'b000);
    chk("t6_rvalid_rst", rvalid, 3'b000);
    next_cycle();
    at_mid();
    chk("t6_gnt_first", gnt, 3'b010);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
